// File: rtl/seq_detector_param_if.sv
// ============================================================================
// Module      : seq_detector_param_if
// Description : Sample/load/result bundle for the serial pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_detector_param_if #(
    parameter int PATTERN_W = 4,
    parameter int CNT_W     = 8
);
    logic                 en;
    logic                 inp;
    logic                 load;
    logic [PATTERN_W-1:0] pattern;
    logic                 out;
    logic [CNT_W-1:0]     match_count;
    logic                 count_sat;

    modport master (
        output en,
        output inp,
        output load,
        output pattern,
        input  out,
        input  match_count,
        input  count_sat
    );

    modport slave (
        input  en,
        input  inp,
        input  load,
        input  pattern,
        output out,
        output match_count,
        output count_sat
    );
endinterface

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module      : seq_detector_param
// Description : Serial bit-pattern detector with runtime-loaded pattern,
//               optional overlap and a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param #(
    parameter int                   PATTERN_W = 4,
    parameter int                   OVERLAP   = 1,
    parameter int                   CNT_W     = 8,
    parameter logic [PATTERN_W-1:0] RST_PAT   = PATTERN_W'(4'b1011)
) (
    input  wire                   clk,
    input  wire                   reset,
    seq_detector_param_if.slave   bus
);

    localparam int                FILL_W      = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0] C_FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);

    logic [PATTERN_W-1:0] hist_q,  hist_d;
    logic [FILL_W-1:0]    fill_q,  fill_d;
    logic [PATTERN_W-1:0] pat_q,   pat_d;
    logic                 out_q,   out_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [PATTERN_W-1:0] w_hist_next;
    logic [FILL_W-1:0]    w_fill_next;
    logic                 w_match;
    logic                 w_sat;

    // History/fill after taking the current bit, used only on enabled edges.
    assign w_hist_next = {hist_q[PATTERN_W-2:0], bus.inp};
    assign w_fill_next = (fill_q == C_FILL_FULL) ? fill_q : (fill_q + C_FILL_ONE);
    // Fill gate keeps zero-padded history from matching a pattern like 0000.
    assign w_match     = (w_fill_next == C_FILL_FULL) && (w_hist_next == pat_q);
    assign w_sat       = &count_q;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        out_d   = 1'b0;
        count_d = count_q;

        if (bus.load) begin
            pat_d  = bus.pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = w_hist_next;
            out_d  = w_match;
            if (w_match && !w_sat) begin
                count_d = count_q + C_CNT_ONE;
            end
            if (w_match && (OVERLAP == 0)) begin
                fill_d = '0;
            end else begin
                fill_d = w_fill_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= RST_PAT;
            out_q   <= 1'b0;
            count_q <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            out_q   <= out_d;
            count_q <= count_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.match_count = count_q;
    assign bus.count_sat   = w_sat;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Directed bench for seq_detector_param across four configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       inp   = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] pat4  = 4'b0000;
    logic [2:0] pat3  = 3'b000;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // u0: W=4 overlap, u1: W=4 non-overlap, u2: W=3 overlap, u3: W=4 with 2-bit counter
    seq_detector_param_if #(.PATTERN_W(4), .CNT_W(8)) if0 ();
    seq_detector_param_if #(.PATTERN_W(4), .CNT_W(8)) if1 ();
    seq_detector_param_if #(.PATTERN_W(3), .CNT_W(8)) if2 ();
    seq_detector_param_if #(.PATTERN_W(4), .CNT_W(2)) if3 ();

    assign if0.en = en;  assign if0.inp = inp;  assign if0.load = load;  assign if0.pattern = pat4;
    assign if1.en = en;  assign if1.inp = inp;  assign if1.load = load;  assign if1.pattern = pat4;
    assign if2.en = en;  assign if2.inp = inp;  assign if2.load = load;  assign if2.pattern = pat3;
    assign if3.en = en;  assign if3.inp = inp;  assign if3.load = load;  assign if3.pattern = pat4;

    seq_detector_param #(.PATTERN_W(4), .OVERLAP(1), .CNT_W(8), .RST_PAT(4'b1011))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    seq_detector_param #(.PATTERN_W(4), .OVERLAP(0), .CNT_W(8), .RST_PAT(4'b1011))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    seq_detector_param #(.PATTERN_W(3), .OVERLAP(1), .CNT_W(8), .RST_PAT(3'b000))
        u2 (.clk(clk), .reset(reset), .bus(if2));
    seq_detector_param #(.PATTERN_W(4), .OVERLAP(1), .CNT_W(2), .RST_PAT(4'b1011))
        u3 (.clk(clk), .reset(reset), .bus(if3));

    // All tasks are entered 1 time unit after a rising edge.
    task automatic step(input logic e, input logic b);
        en   = e;
        inp  = b;
        load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load_pulse();
        load = 1'b1;
        en   = 1'b1;
        inp  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        en   = 1'b0;
    endtask

    task automatic do_reset();
        en    = 1'b0;
        load  = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL reset_out: got %b want 0", if0.out); end
        n_vec++; if (if0.match_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", if0.match_count); end
        n_vec++; if (if0.count_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", if0.count_sat); end
        n_vec++; if (if3.match_count !== 2'd0) begin n_err++; $display("FAIL reset_count_w2: got %0d want 0", if3.match_count); end
        reset = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001001;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s[6-i]);
            n_vec++;
            if (if0.out !== e[6-i]) begin
                n_err++; $display("FAIL overlap_out bit%0d: got %b want %b", i + 1, if0.out, e[6-i]);
            end
        end
        n_vec++; if (if0.match_count !== 8'd2) begin n_err++; $display("FAIL overlap_count: got %0d want 2", if0.match_count); end
    endtask

    task automatic test_nonoverlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s[6-i]);
            n_vec++;
            if (if1.out !== e[6-i]) begin
                n_err++; $display("FAIL nonoverlap_out bit%0d: got %b want %b", i + 1, if1.out, e[6-i]);
            end
        end
        n_vec++; if (if1.match_count !== 8'd1) begin n_err++; $display("FAIL nonoverlap_count: got %0d want 1", if1.match_count); end
    endtask

    task automatic test_w3();
        logic [9:0] s = 10'b0101001010;
        logic [9:0] e = 10'b0001000010;
        do_reset();
        pat3 = 3'b101;
        load_pulse();
        n_vec++; if (if2.out !== 1'b0) begin n_err++; $display("FAIL w3_load_out: got %b want 0", if2.out); end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, s[9-i]);
            n_vec++;
            if (if2.out !== e[9-i]) begin
                n_err++; $display("FAIL w3_out bit%0d: got %b want %b", i + 1, if2.out, e[9-i]);
            end
        end
        n_vec++; if (if2.match_count !== 8'd2) begin n_err++; $display("FAIL w3_count: got %0d want 2", if2.match_count); end
    endtask

    task automatic test_saturate();
        logic       exp_out;
        logic [1:0] exp_cnt;
        do_reset();
        pat4 = 4'b1111;
        load_pulse();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            exp_out = (i >= 3);
            exp_cnt = (i < 3) ? 2'd0 : ((i - 2) >= 3 ? 2'd3 : 2'(i - 2));
            n_vec++;
            if (if3.out !== exp_out) begin
                n_err++; $display("FAIL sat_out bit%0d: got %b want %b", i + 1, if3.out, exp_out);
            end
            n_vec++;
            if (if3.match_count !== exp_cnt) begin
                n_err++; $display("FAIL sat_count bit%0d: got %0d want %0d", i + 1, if3.match_count, exp_cnt);
            end
        end
        n_vec++; if (if3.count_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", if3.count_sat); end
    endtask

    task automatic test_async_reset();
        logic [3:0] s = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, s[3-i]);
        n_vec++; if (if0.out !== 1'b1) begin n_err++; $display("FAIL async_pre_out: got %b want 1", if0.out); end
        n_vec++; if (if0.match_count !== 8'd1) begin n_err++; $display("FAIL async_pre_count: got %0d want 1", if0.match_count); end
        #2; reset = 1'b1; #1;
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL async_out: got %b want 0", if0.out); end
        n_vec++; if (if0.match_count !== 8'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", if0.match_count); end
        reset = 1'b0;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        #2; reset = 1'b1; #1; reset = 1'b0;
        step(1'b1, 1'b1);
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL async_discard: got %b want 0", if0.out); end
        step(1'b1, 1'b0); step(1'b1, 1'b1);
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL async_partial: got %b want 0", if0.out); end
        step(1'b1, 1'b1);
        n_vec++; if (if0.out !== 1'b1) begin n_err++; $display("FAIL async_fresh_match: got %b want 1", if0.out); end
    endtask

    task automatic test_gap_and_zero();
        do_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL gap_out1: got %b want 0", if0.out); end
        step(1'b0, 1'b0);
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL gap_out2: got %b want 0", if0.out); end
        step(1'b1, 1'b1);
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL gap_out3: got %b want 0", if0.out); end
        step(1'b1, 1'b1);
        n_vec++; if (if0.out !== 1'b1) begin n_err++; $display("FAIL gap_match: got %b want 1", if0.out); end
        pat4 = 4'b0000;
        load_pulse();
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL zero_load_out: got %b want 0", if0.out); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            n_vec++;
            if (if0.out !== 1'b0) begin n_err++; $display("FAIL zero_partial bit%0d: got %b want 0", i + 1, if0.out); end
        end
        step(1'b1, 1'b0);
        n_vec++; if (if0.out !== 1'b1) begin n_err++; $display("FAIL zero_match: got %b want 1", if0.out); end
        n_vec++; if (if0.match_count !== 8'd2) begin n_err++; $display("FAIL zero_count: got %0d want 2", if0.match_count); end
        step(1'b0, 1'b0);
        n_vec++; if (if0.out !== 1'b0) begin n_err++; $display("FAIL pulse_width: got %b want 0", if0.out); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_w3();
        test_saturate();
        test_async_reset();
        test_gap_and_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
